// File: rtl/spi_cmd_executor.sv
// SPI command executor: shadow bank of channel words, serial shift-out
// to daisy-chained driver ICs with latch pulse, and frame error counting.
module spi_cmd_executor #(
  parameter int         NUM_CH      = 16,
  parameter int         DATA_W      = 16,
  parameter int         CLK_DIV     = 4,
  parameter logic [2:0] WR_OPCODE   = 3'b001,
  parameter logic [2:0] LOAD_OPCODE = 3'b010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] spi_data,
  input  logic        spi_listener_interrupt,
  output logic        ser_sdo,
  output logic        ser_sclk,
  output logic        ser_le,
  output logic        busy,
  output logic        load_done,
  output logic [7:0]  frame_err_cnt
);

  localparam int NBITS = NUM_CH * DATA_W;
  localparam int BW    = $clog2(NBITS + 1);
  localparam int DW    = $clog2(CLK_DIV + 1);

  localparam logic [BW-1:0] BITS_ALL = BW'(NBITS);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_LATCH,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [NBITS-1:0]  sr_q, sr_d;
  logic [NBITS-1:0]  bank;
  logic              pending_q, pending_d;
  logic [7:0]        err_q, err_d;
  logic [DATA_W-1:0] shadow_q [NUM_CH];
  logic [DATA_W-1:0] shadow_d [NUM_CH];

  logic [2:0]  op;
  logic [4:0]  addr;
  logic [15:0] pl;
  logic        is_wr, is_load, addr_ok, bad;
  logic        start, consume, div_last;

  assign op      = spi_data[23:21];
  assign addr    = spi_data[20:16];
  assign pl      = spi_data[15:0];
  assign is_wr   = spi_listener_interrupt && (op == WR_OPCODE);
  assign is_load = spi_listener_interrupt && (op == LOAD_OPCODE);
  assign addr_ok = addr < 5'(NUM_CH);
  assign bad     = spi_listener_interrupt &&
                   ((op == WR_OPCODE && !addr_ok) ||
                    (op != WR_OPCODE && op != LOAD_OPCODE &&
                     op != 3'b000));
  assign div_last = (div_q == DIV_LAST);

  // Channel NUM_CH-1 sits at the top so it leaves the chain first
  always_comb begin
    bank = '0;
    for (int c = 0; c < NUM_CH; c++)
      bank[c*DATA_W +: DATA_W] = shadow_q[c];
  end

  always_comb begin
    shadow_d = shadow_q;
    for (int c = 0; c < NUM_CH; c++)
      if (is_wr && addr == 5'(c))
        shadow_d[c] = DATA_W'(pl);
    err_d = (bad && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    pending_d = pending_q;
    start     = 1'b0;
    consume   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        start   = is_load || pending_q;
        consume = pending_q;
      end
      S_LO: begin
        div_d = div_q + DIV_ONE;
        if (div_last) begin
          div_d   = '0;
          state_d = S_HI;
        end
      end
      S_HI: begin
        div_d = div_q + DIV_ONE;
        if (div_last) begin
          div_d   = '0;
          sr_d    = {sr_q[NBITS-2:0], 1'b0};
          bit_d   = bit_q - BIT_ONE;
          state_d = (bit_q == BIT_ONE) ? S_LATCH : S_LO;
        end
      end
      S_LATCH: begin
        div_d = div_q + DIV_ONE;
        if (div_last) begin
          div_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        start   = pending_q;
        consume = pending_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      sr_d    = bank;
      bit_d   = BITS_ALL;
      div_d   = '0;
      state_d = S_LO;
    end
    // A LOAD that coincides with pending being consumed is merged
    if (consume)
      pending_d = 1'b0;
    else if (is_load && state_q != S_IDLE)
      pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      pending_q <= 1'b0;
      err_q     <= '0;
      for (int c = 0; c < NUM_CH; c++)
        shadow_q[c] <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      shadow_q  <= shadow_d;
    end
  end

  assign ser_sclk      = (state_q == S_HI);
  assign ser_le        = (state_q == S_LATCH);
  assign load_done     = (state_q == S_DONE);
  assign ser_sdo       = (state_q == S_LO || state_q == S_HI) &&
                         sr_q[NBITS-1];
  assign busy          = (state_q != S_IDLE) || pending_q;
  assign frame_err_cnt = err_q;

endmodule

// File: doc/spi_cmd_executor.md
Name: spi_cmd_executor

Overview:
- Sits directly downstream of the SPI frame listener and consumes its 24-bit frames (`spi_data`, one-cycle `spi_listener_interrupt`).
- Decodes write and load commands into a shadow register bank, one word per channel.
- On a load command, serially shifts the whole bank out to the daisy-chained array driver ICs and pulses the latch enable.
- Counts malformed frames for diagnostics.

Parameters:
- NUM_CH, 16, number of channel words in the bank (2..31).
- DATA_W, 16, bits per channel word (fixed to frame payload width).
- CLK_DIV, 4, clk cycles per `ser_sclk` half-period and `ser_le` pulse width (>=1).
- WR_OPCODE, 3'b001, opcode for the channel write command.
- LOAD_OPCODE, 3'b010, opcode for the shift-and-latch command.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- spi_data  in  24  frame from listener: [23:21] opcode, [20:16] address, [15:0] payload.
- spi_listener_interrupt  in  1  one-cycle frame-valid strobe.
- ser_sdo  out  1  serial data to driver chain.
- ser_sclk  out  1  serial clock to driver chain; idle low.
- ser_le  out  1  latch enable to driver chain; active high.
- busy  out  1  serializer active or load pending.
- load_done  out  1  one-cycle pulse when latch completes.
- frame_err_cnt  out  8  saturating count of rejected frames.

Behaviour:
- Reset values: all shadow words 0, pending 0, all outputs 0, serializer in IDLE. Reset is asynchronous and takes effect immediately, including mid-shift. `ser_le` is never asserted for an aborted transfer.
- Decode happens only on the clk edge where `spi_listener_interrupt` is 1. Fields: op=[23:21], addr=[20:16], pl=[15:0].
- op==WR_OPCODE, addr<NUM_CH: shadow[addr]<=pl at that edge. Writes are allowed while busy; they affect only the shadow bank, never the transfer in flight.
- op==WR_OPCODE, addr>=NUM_CH: no write; frame_err_cnt+1.
- op==LOAD_OPCODE (addr and payload ignored):
  - If IDLE and not pending: the shift register (NUM_CH*DATA_W bits) is loaded from shadow at that edge. A write in the same frame cannot coexist, since one frame is one command. `busy`=1 from the next cycle.
  - If a transfer is active: set pending=1.
  - If pending is already 1: ignored, merged; not an error.
- op==3'b000: NOP, ignored.
- Any other opcode: frame_err_cnt+1.
- frame_err_cnt saturates at 255 and holds.
- Serializer FSM: IDLE -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO | LATCH) -> DONE -> IDLE.
  - SHIFT_LO: `ser_sclk`=0 and `ser_sdo`=current MSB for CLK_DIV cycles.
  - SHIFT_HI: `ser_sclk`=1 for CLK_DIV cycles. On exit, shift left by 1 and decrement the bit counter.
  - Bit order: channel NUM_CH-1 bit DATA_W-1 first; channel 0 bit 0 last.
  - After NUM_CH*DATA_W bits go to LATCH: `ser_sclk`=0, `ser_sdo`=0, `ser_le`=1 for CLK_DIV cycles.
  - DONE (one cycle): `load_done`=1.
    - If pending: clear pending, reload shift register from the current shadow bank, go to SHIFT_LO; `busy` stays 1.
    - Otherwise go to IDLE; `busy`=0 from the next cycle.
- A LOAD frame arriving in the same cycle as DONE sets pending only if the FSM is not consuming pending that cycle. If pending is already being consumed, the new LOAD is merged.
- Timing with defaults: first SHIFT_LO begins the cycle after the LOAD strobe. `ser_le` rises after 256*2*4=2048 cycles. `load_done` occurs 2048+4 cycles after SHIFT_LO entry.
- Bit counter width: clog2(NUM_CH*DATA_W+1). Divider counter width: clog2(CLK_DIV+1).

Test Plan:
- Reset, then write frames 0x20ABCD (ch0=0xABCD) and 0x2F1234 (ch15=0x1234), then 0x400000 -> 256 sclk rising edges. First 16 sampled bits = 0x1234, last 16 = 0xABCD, others 0. `ser_le` high 4 cycles. `load_done` pulses once. `busy` low 1 cycle after DONE.
- Frames 0x3F0001 (addr 31 >= NUM_CH) and 0xE00000 (opcode 7) -> frame_err_cnt=2, shadow unchanged. 0x000000 -> count stays 2.
- LOAD, then write ch0=0x5555 and two more LOADs mid-transfer -> first transfer carries the old ch0 value. Exactly one back-to-back second transfer carries 0x5555. Two `load_done` pulses total.
- 300 invalid-opcode frames -> frame_err_cnt saturates at 255.
- Assert `rst` at bit 100 of a transfer -> all outputs 0 immediately. No `ser_le` pulse. Subsequent LOAD shifts all zeros.
- CLK_DIV=1 build, NUM_CH=2 -> transfer length 64+1 cycles to `load_done`, sclk period 2 cycles.
